// File: rtl/water_pkg.sv
`default_nettype none
// ============================================================================
// Module      : water_pkg
// Description : Shared types and constants for the drink reminder controller.
// Revision    : 1.0 - initial release
// ============================================================================
package water_pkg;

    localparam int LEVEL_W = 4;   // bottle level width
    localparam int TIMER_W = 8;   // tick timer / interval width
    localparam int REF_W   = 8;   // baseline level register width

    localparam int DEF_DRINK_DELTA    = 1;
    localparam int DEF_ESCALATE_TICKS = 30;
    localparam int DEF_SNOOZE_TICKS   = 60;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_REMIND = 2'd1,
        ST_ALARM  = 2'd2,
        ST_SNOOZE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tick_counter.sv
`default_nettype none
// ============================================================================
// Module      : tick_counter
// Description : Clearable tick counter with a terminal-value compare. The done
//               flag uses >= so a terminal lowered below the current count
//               still fires on the next qualifying tick.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_terminal,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    // Count enabled ticks; clear has priority over counting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_done = (r_count >= i_terminal);

endmodule
`default_nettype wire

// File: rtl/drink_reminder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : drink_reminder_ctrl
// Description : Hydration reminder FSM. Tracks drinks from bottle-level drops,
//               reminds after a programmable interval, escalates to a buzzer,
//               and supports a user snooze.
// Revision    : 1.0 - initial release
// ============================================================================
module drink_reminder_ctrl
    import water_pkg::*;
#(
    parameter int DRINK_DELTA    = DEF_DRINK_DELTA,
    parameter int ESCALATE_TICKS = DEF_ESCALATE_TICKS,
    parameter int SNOOZE_TICKS   = DEF_SNOOZE_TICKS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic [LEVEL_W-1:0] level,
    input  logic               ack,
    input  logic [TIMER_W-1:0] interval,
    output logic               remind,
    output logic               buzzer,
    output logic [LEVEL_W-1:0] drinks,
    output logic [1:0]         state_o
);

    state_t             r_state;
    logic [REF_W-1:0]   r_ref_level;
    logic               r_primed;
    logic [LEVEL_W-1:0] r_drinks;
    logic               r_remind;
    logic               r_buzzer;

    state_t             w_next_state;
    logic [LEVEL_W:0]   w_sum;
    logic               w_drink;
    logic               w_refill;
    logic               w_clear;
    logic               w_en;
    logic               w_done;
    logic [TIMER_W-1:0] w_terminal;

    // Terminal count for the timer depends on which state is being timed.
    always_comb begin
        w_terminal = '0;
        case (r_state)
            ST_WAIT:   w_terminal = interval - TIMER_W'(1);
            ST_REMIND: w_terminal = TIMER_W'(ESCALATE_TICKS - 1);
            ST_SNOOZE: w_terminal = TIMER_W'(SNOOZE_TICKS - 1);
            default:   w_terminal = '0;
        endcase
    end

    tick_counter #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_clear),
        .i_en       (w_en),
        .i_terminal (w_terminal),
        .o_done     (w_done)
    );

    // Event decode and next-state selection; priority is drink, then ack, then tick.
    always_comb begin
        // One extra bit keeps level + DRINK_DELTA from wrapping past full.
        w_sum        = {1'b0, level} + (LEVEL_W + 1)'(DRINK_DELTA);
        w_drink      = r_primed && ({{(REF_W-LEVEL_W-1){1'b0}}, w_sum} <= r_ref_level);
        w_refill     = r_primed && ({{(REF_W-LEVEL_W){1'b0}}, level} > r_ref_level);
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_en         = 1'b0;
        if (w_drink) begin
            w_next_state = ST_WAIT;
            w_clear      = 1'b1;
        end else if (ack && (r_state == ST_REMIND || r_state == ST_ALARM)) begin
            w_next_state = ST_SNOOZE;
            w_clear      = 1'b1;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (interval == '0) begin
                        w_clear = 1'b1;
                    end else if (tick) begin
                        if (w_done) begin
                            w_next_state = ST_REMIND;
                            w_clear      = 1'b1;
                        end else begin
                            w_en = 1'b1;
                        end
                    end
                end
                ST_REMIND: begin
                    if (tick) begin
                        if (w_done) begin
                            w_next_state = ST_ALARM;
                            w_clear      = 1'b1;
                        end else begin
                            w_en = 1'b1;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (tick) begin
                        if (w_done) begin
                            w_next_state = ST_REMIND;
                            w_clear      = 1'b1;
                        end else begin
                            w_en = 1'b1;
                        end
                    end
                end
                default: begin
                    w_next_state = r_state;
                end
            endcase
        end
    end

    // State, baseline, drink count and registered indicator outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_WAIT;
            r_ref_level <= '0;
            r_primed    <= 1'b0;
            r_drinks    <= '0;
            r_remind    <= 1'b0;
            r_buzzer    <= 1'b0;
        end else begin
            if (!r_primed) begin
                r_primed    <= 1'b1;
                r_ref_level <= {{(REF_W-LEVEL_W){1'b0}}, level};
            end else if (w_drink || w_refill) begin
                r_ref_level <= {{(REF_W-LEVEL_W){1'b0}}, level};
            end
            if (w_drink && (r_drinks != '1)) begin
                r_drinks <= r_drinks + LEVEL_W'(1);
            end
            r_state  <= w_next_state;
            r_remind <= (w_next_state == ST_REMIND) || (w_next_state == ST_ALARM);
            r_buzzer <= (w_next_state == ST_ALARM);
        end
    end

    assign remind  = r_remind;
    assign buzzer  = r_buzzer;
    assign drinks  = r_drinks;
    assign state_o = r_state;

endmodule
`default_nettype wire

// File: doc/drink_reminder_ctrl.md
DRINK_REMINDER_CTRL -- requirements
Module: drink_reminder_ctrl

Interface
REQ-001 Parameter DRINK_DELTA, default 1, minimum level drop (in level units) that counts as a drink.
REQ-002 Parameter ESCALATE_TICKS, default 30, ticks in REMIND before escalating to ALARM.
REQ-003 Parameter SNOOZE_TICKS, default 60, ticks spent in SNOOZE before reminding again.
REQ-004 clk  input  1  single system clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-low (0 = reset).
REQ-006 tick  input  1  one-cycle timebase strobe (nominally 1 Hz).
REQ-007 level  input  4  stable bottle level from the water-level filter, 0 = empty, 15 = full.
REQ-008 ack  input  1  debounced user-button pulse, one cycle.
REQ-009 interval  input  8  reminder interval in ticks; 0 disables reminders.
REQ-010 remind  output  1  reminder indicator.
REQ-011 buzzer  output  1  escalated alarm.
REQ-012 drinks  output  4  drink count since reset, saturating.
REQ-013 state_o  output  2  current FSM state encoding.

Function
REQ-014 The FSM SHALL have states WAIT=0, REMIND=1, ALARM=2, SNOOZE=3; all outputs registered.
REQ-015 remind SHALL be 1 in REMIND and ALARM, 0 otherwise; buzzer SHALL be 1 only in ALARM.
REQ-016 An 8-bit baseline register ref_level SHALL be loaded from level on the first clock after reset release (primed flag set) with no drink counted.
REQ-017 Once primed, drink event SHALL be level + DRINK_DELTA <= ref_level, computed in 5 bits to avoid wrap.
REQ-018 On drink: ref_level <= level, drinks +1 saturating at 15, timer cleared, next state WAIT from any state.
REQ-019 On level > ref_level (refill): ref_level <= level, no drink counted, timer and state unchanged.
REQ-020 Drop smaller than DRINK_DELTA SHALL leave ref_level unchanged.
REQ-021 WAIT: on tick, if interval != 0 and timer == interval-1 then go REMIND and clear timer, else timer +1.
REQ-022 WAIT with interval == 0: timer held at 0, no transition; ack ignored.
REQ-023 REMIND: on tick, timer == ESCALATE_TICKS-1 -> ALARM, timer cleared; else timer +1.
REQ-024 REMIND or ALARM: ack -> SNOOZE, timer cleared.
REQ-025 SNOOZE: on tick, timer == SNOOZE_TICKS-1 -> REMIND, timer cleared; ack ignored.
REQ-026 Same-cycle priority: drink > ack > tick.
REQ-027 interval change mid-count SHALL take effect on the next tick comparison; if timer >= new interval-1, the next tick fires REMIND.
REQ-028 Latency: remind/buzzer change on the clock edge that samples the causing tick, ack or drink.

Reset
REQ-029 Asserting reset at any time SHALL immediately force state WAIT, timer 0, drinks 0, ref_level 0, primed 0, remind 0, buzzer 0.
REQ-030 Reset mid-REMIND/ALARM SHALL drop remind and buzzer asynchronously, without waiting for clk.

Structure
REQ-031 Shared package water_pkg SHALL hold the state enum, LEVEL_W=4, TIMER_W=8, and parameter defaults.
REQ-032 The timer SHALL be a sub-module tick_counter (clear, tick enable, terminal-value compare, done flag).

Verification
REQ-033 Prime level=15, interval=3, tick every 4 clk -> remind=1 one clock after third tick; drinks=0.
REQ-034 In REMIND, ESCALATE_TICKS=2, no ack -> buzzer=1 after 2 further ticks; ack -> SNOOZE, remind=0, buzzer=0.
REQ-035 In ALARM, level 15->12 with tick and ack in same cycle -> WAIT, drinks=1, ref_level=12, timer=0.
REQ-036 level 12->15 (refill) during WAIT timer=2 -> no drink counted, timer continues, remind at scheduled tick.
REQ-037 interval=0, 100 ticks -> remains WAIT, remind=0; 16 drinks -> drinks saturates at 15.
REQ-038 reset low mid-ALARM between clk edges -> remind, buzzer 0 immediately; after release, first level sampled as baseline.
